tt_um_array_divider_hhrb98: RTL and testbench

Sequential 8-bit by 4-bit unsigned restoring divider. It is the inverse companion to the team's 4x4 array multiplier tile. It takes an 8-bit dividend, which is the multiplier's product range, and a 4-bit divisor, and returns a 4-bit quotient and a 4-bit remainder packed into one byte. It uses one iteration per clock, a start/done handshake on the bidirectional pins, and flags divide-by-zero and quotient overflow.

---
 rtl/tt_um_array_divider_hhrb98.sv | 121 ++++++++++++
 tb/tb_tt_um_array_divider_hhrb98.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_array_divider_hhrb98.sv
// Sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock.
// Packs {remainder, quotient} into uo_out and flags divide-by-zero / quotient overflow.
`timescale 1ns/1ps
module tt_um_array_divider_hhrb98 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        start_q;
  logic [1:0]  cnt, cnt_nxt;
  logic [3:0]  d_reg, d_nxt;
  logic [4:0]  p, p_nxt;
  logic [3:0]  qr, qr_nxt;
  logic [7:0]  res, res_nxt;
  logic        busy, busy_nxt;
  logic        done, done_nxt;
  logic        err, err_nxt;

  logic        launch;
  logic [4:0]  s, t;
  logic        ge;
  logic [4:0]  step_p;
  logic [3:0]  step_q;
  logic        unused_bits;

  // P < D always holds, so P[4] is structurally zero and never feeds the shift.
  assign unused_bits = &{uio_in[7:5], p[4]};

  assign launch = ena & uio_in[4] & ~start_q & (state != S_RUN);
  assign s      = {p[3:0], qr[3]};
  assign t      = s - {1'b0, d_reg};
  assign ge     = (s >= {1'b0, d_reg});
  assign step_p = ge ? t : s;
  assign step_q = {qr[2:0], ge};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d_reg;
    p_nxt     = p;
    qr_nxt    = qr;
    res_nxt   = res;
    busy_nxt  = busy;
    done_nxt  = done;
    err_nxt   = err;
    case (state)
      S_IDLE, S_DONE: begin
        if (launch) begin
          if ((uio_in[3:0] == 4'd0) || (ui_in[7:4] >= uio_in[3:0])) begin
            state_nxt = S_DONE;
            res_nxt   = '1;
            err_nxt   = 1'b1;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = S_RUN;
            d_nxt     = uio_in[3:0];
            p_nxt     = {1'b0, ui_in[7:4]};
            qr_nxt    = ui_in[3:0];
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            done_nxt  = 1'b0;
            busy_nxt  = 1'b1;
          end
        end
      end
      S_RUN: begin
        p_nxt   = step_p;
        qr_nxt  = step_q;
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_nxt = S_DONE;
          res_nxt   = {step_p[3:0], step_q};
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      cnt     <= '0;
      d_reg   <= '0;
      p       <= '0;
      qr      <= '0;
      res     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= uio_in[4];
      cnt     <= cnt_nxt;
      d_reg   <= d_nxt;
      p       <= p_nxt;
      qr      <= qr_nxt;
      res     <= res_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  assign uo_out  = res;
  assign uio_out = {err, done, busy, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_array_divider_hhrb98.sv
// Directed bench for the 8/4 restoring divider: vector table, handshake corner cases,
// reset abort, exhaustive operand sweep and multiplier cross-check.
`timescale 1ns/1ps
module tb_tt_um_array_divider_hhrb98;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tt_um_array_divider_hhrb98 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [7:0] exp_uo;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle with start low, launch, then wait (bounded) for done.
  task automatic do_op(input logic [7:0] n, input logic [3:0] d,
                       output logic [7:0] uo, output logic e,
                       output int lat, output int busy_cnt);
    uio_in[4] = 1'b0;
    tick();
    ui_in  = n;
    uio_in = {3'b000, 1'b1, d};
    tick();
    uio_in[4] = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!uio_out[6] && lat < 20) begin
      if (uio_out[5]) busy_cnt++;
      tick();
      lat++;
    end
    uo = uo_out;
    e  = uio_out[7];
  endtask

  initial begin
    logic [7:0] uo;
    logic       e;
    int         lat, bc;
    logic [7:0] exp_uo;
    logic       exp_e;
    logic [7:0] prod;

    vecs[0]  = '{8'd100, 4'd7,  8'h2E, 1'b0};
    vecs[1]  = '{8'd225, 4'd15, 8'h0F, 1'b0};
    vecs[2]  = '{8'd0,   4'd1,  8'h00, 1'b0};
    vecs[3]  = '{8'd240, 4'd15, 8'hFF, 1'b1};
    vecs[4]  = '{8'd37,  4'd0,  8'hFF, 1'b1};
    vecs[5]  = '{8'd143, 4'd11, 8'h0D, 1'b0};
    vecs[6]  = '{8'd255, 4'd15, 8'hFF, 1'b1};
    vecs[7]  = '{8'd200, 4'd13, 8'h5F, 1'b0};
    vecs[8]  = '{8'd50,  4'd3,  8'hFF, 1'b1};
    vecs[9]  = '{8'd47,  4'd3,  8'h2F, 1'b0};
    vecs[10] = '{8'd17,  4'd2,  8'h18, 1'b0};
    vecs[11] = '{8'd99,  4'd10, 8'h99, 1'b0};

    rst_n = 1'b0; ena = 1'b1; ui_in = '0; uio_in = '0;
    #12;
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hE0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].n, vecs[i].d, uo, e, lat, bc);
      check($sformatf("vec%0d uo_out", i), uo, vecs[i].exp_uo);
      check($sformatf("vec%0d err", i), e, vecs[i].exp_err);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_err ? 0 : 4);
      check($sformatf("vec%0d busy cycles", i), bc, vecs[i].exp_err ? 0 : 4);
    end

    // Input churn and start toggling during RUN; start edge on the completing edge.
    uio_in[4] = 1'b0; tick();
    ui_in = 8'd100; uio_in = {3'b000, 1'b1, 4'd7}; tick();
    uio_in[4] = 1'b0; tick();
    ui_in = 8'd5; uio_in = {3'b000, 1'b1, 4'd2}; tick();
    uio_in[4] = 1'b0; tick();
    uio_in[4] = 1'b1; tick();
    check("churn done", uio_out[6], 1'b1);
    check("churn uo_out", uo_out, 8'h2E);
    check("churn err", uio_out[7], 1'b0);
    repeat (4) tick();
    check("hold start busy", uio_out[5], 1'b0);
    check("hold start done", uio_out[6], 1'b1);
    check("hold start uo_out", uo_out, 8'h2E);
    uio_in[4] = 1'b0; tick();

    // ena low masks launches but does not stall a running operation.
    ena = 1'b0;
    ui_in = 8'd17; uio_in = {3'b000, 1'b1, 4'd2}; tick();
    uio_in[4] = 1'b0; tick();
    check("ena low busy", uio_out[5], 1'b0);
    check("ena low uo_out", uo_out, 8'h2E);
    ena = 1'b1;
    uio_in[4] = 1'b1; tick();
    ena = 1'b0; uio_in[4] = 1'b0;
    repeat (4) tick();
    check("ena drop done", uio_out[6], 1'b1);
    check("ena drop uo_out", uo_out, 8'h18);
    ena = 1'b1;

    // Asynchronous reset after step 2.
    tick();
    ui_in = 8'd100; uio_in = {3'b000, 1'b1, 4'd7}; tick();
    uio_in[4] = 1'b0; tick(); tick();
    check("pre-reset busy", uio_out[5], 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset uo_out", uo_out, 8'h00);
    check("async reset uio_out", uio_out, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("post-reset idle uio_out", uio_out, 8'h00);
    do_op(8'd143, 4'd11, uo, e, lat, bc);
    check("post-reset uo_out", uo, 8'h0D);
    check("post-reset latency", lat, 4);

    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        do_op(n[7:0], d[3:0], uo, e, lat, bc);
        exp_e = (d == 0) || ((n / 16) >= d);
        exp_uo = exp_e ? 8'hFF : {4'(n % d), 4'(n / d)};
        check($sformatf("sweep %0d/%0d err", n, d), e, exp_e);
        check($sformatf("sweep %0d/%0d uo_out", n, d), uo, exp_uo);
      end
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        prod = 8'(a * b);
        do_op(prod, b[3:0], uo, e, lat, bc);
        check($sformatf("mul %0d*%0d", a, b), {e, uo}, {1'b0, 4'd0, a[3:0]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
